// File: rtl/up_down_counter_monitor.sv
// Checks that an up/down counter steps by exactly +/-1 per clock, reports wraps and direction flips,
// and latches the first illegal step until cleared. All outputs registered, one cycle after the checked edge.
module up_down_counter_monitor #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      y,
  input  logic                  clr,
  output logic                  wrap_up,
  output logic                  wrap_dn,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  dir_flip,
  output logic                  step_err,
  output logic [WIDTH-1:0]      err_y,
  output logic                  tracking
);

  typedef enum logic [1:0] {EMPTY, TRACK, FAULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] y_prev;
  logic             dir_prev;
  logic [WIDTH-1:0] exp_y;
  logic             is_wrap_up;
  logic             is_wrap_dn;

  // Expected value uses the direction captured alongside y_prev, as the counter does.
  assign exp_y      = dir_prev ? y_prev + 1'b1 : y_prev - 1'b1;
  assign is_wrap_up = dir_prev  && (y_prev == '1) && (y == '0);
  assign is_wrap_dn = !dir_prev && (y_prev == '0) && (y == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      y_prev     <= '0;
      dir_prev   <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      wrap_count <= '0;
      dir_flip   <= 1'b0;
      step_err   <= 1'b0;
      err_y      <= '0;
      tracking   <= 1'b0;
    end else begin
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      dir_flip <= 1'b0;
      if (clr) begin
        // Clear wins over any wrap or mismatch seen at the same edge.
        state      <= EMPTY;
        wrap_count <= '0;
        step_err   <= 1'b0;
        err_y      <= '0;
        tracking   <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            y_prev   <= y;
            dir_prev <= dir;
            state    <= TRACK;
            tracking <= 1'b1;
          end
          TRACK: begin
            dir_flip <= (dir != dir_prev);
            if (y == exp_y) begin
              y_prev   <= y;
              dir_prev <= dir;
              wrap_up  <= is_wrap_up;
              wrap_dn  <= is_wrap_dn;
              if ((is_wrap_up || is_wrap_dn) && (wrap_count != '1))
                wrap_count <= wrap_count + 1'b1;
            end else begin
              state    <= FAULT;
              step_err <= 1'b1;
              err_y    <= y;
              tracking <= 1'b0;
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            state    <= EMPTY;
            tracking <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_up_down_counter_monitor.sv
// Bench for up_down_counter_monitor: the bench plays the counter, a transaction model predicts
// every registered output and the prediction is queued at drive time, popped after the edge.
module tb_up_down_counter_monitor;

  localparam int WCW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           dir;
  logic [3:0]     y;
  logic           clr;
  logic           wrap_up, wrap_dn, dir_flip, step_err, tracking;
  logic [WCW-1:0] wrap_count;
  logic [3:0]     err_y;

  up_down_counter_monitor #(.WIDTH(4), .WRAP_CNT_W(WCW)) dut (
    .clk(clk), .reset(reset), .dir(dir), .y(y), .clr(clr),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .wrap_count(wrap_count),
    .dir_flip(dir_flip), .step_err(step_err), .err_y(err_y), .tracking(tracking)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           wu;
    logic           wd;
    logic [WCW-1:0] wc;
    logic           fl;
    logic           se;
    logic [3:0]     ey;
    logic           tr;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o, obs_o;
  int   tests = 0;
  int   failed = 0;
  logic [3:0] cy;
  int   n_wu, n_wd, n_fl;

  // Reference model state: 0 = no history, 1 = checking, 2 = faulted
  int   m_st, m_yp, m_cnt, m_ey;
  logic m_dp, m_err;

  function automatic obs_t snap();
    obs_t o;
    o.wu = wrap_up; o.wd = wrap_dn; o.wc = wrap_count; o.fl = dir_flip;
    o.se = step_err; o.ey = err_y; o.tr = tracking;
    return o;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_yp = 0; m_cnt = 0; m_ey = 0; m_dp = 1'b0; m_err = 1'b0;
  endfunction

  function automatic obs_t model(input logic [3:0] yv, input logic dv, input logic cv);
    obs_t e;
    int   yi;
    int   want;
    yi = int'(yv);
    e = '0;
    if (cv) begin
      m_st = 0; m_cnt = 0; m_err = 1'b0; m_ey = 0;
    end else if (m_st == 0) begin
      m_yp = yi; m_dp = dv; m_st = 1;
    end else if (m_st == 1) begin
      e.fl = (dv != m_dp);
      want = m_dp ? (m_yp + 1) % 16 : (m_yp + 15) % 16;
      if (yi == want) begin
        e.wu = m_dp && m_yp == 15;
        e.wd = !m_dp && m_yp == 0;
        if ((e.wu || e.wd) && m_cnt < (1 << WCW) - 1) m_cnt++;
        m_yp = yi; m_dp = dv;
      end else begin
        m_st = 2; m_err = 1'b1; m_ey = yi;
      end
    end
    e.wc = m_cnt[WCW-1:0];
    e.se = m_err;
    e.ey = m_ey[3:0];
    e.tr = (m_st == 1);
    return e;
  endfunction

  task automatic drive(input logic [3:0] yv, input logic dv, input logic cv);
    y = yv; dir = dv; clr = cv;
    sb.push_back(model(yv, dv, cv));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; y = 4'd0; dir = 1'b1; clr = 1'b0;
    model_reset();
    #6;
    tests++;
    if (snap() !== obs_t'(0)) begin failed++; $display("FAIL reset_held: got %h want 0", snap()); end
    #1 reset = 1'b0;
    #1;
    tests++;
    if (snap() !== obs_t'(0)) begin failed++; $display("FAIL reset_released: got %h want 0", snap()); end
  endtask

  task automatic test_up_run();
    n_wu = 0; n_wd = 0; n_fl = 0;
    cy = 4'd0;
    for (int i = 0; i < 17; i++) begin
      // Last step presents y=0 with dir already lowered for the reversal
      drive(cy, (i < 16), 1'b0);
      cy = (i < 16) ? cy + 4'd1 : cy - 4'd1;
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o) begin failed++; $display("FAIL up_run[%0d]: got %h want %h", i, obs_o, exp_o); end
      n_wu += int'(wrap_up); n_wd += int'(wrap_dn); n_fl += int'(dir_flip);
      if (step_err) begin tests++; failed++; $display("FAIL up_run_err[%0d]: got 1 want 0", i); end
    end
    tests++;
    if (n_wu != 1 || wrap_count !== 2'd1) begin
      failed++; $display("FAIL up_run_wrap: got pulses=%0d count=%0d want 1/1", n_wu, wrap_count);
    end
  endtask

  task automatic test_reversal();
    for (int i = 0; i < 16; i++) begin
      drive(cy, 1'b0, 1'b0);
      cy = cy - 4'd1;
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o) begin failed++; $display("FAIL reversal[%0d]: got %h want %h", i, obs_o, exp_o); end
      n_wu += int'(wrap_up); n_wd += int'(wrap_dn); n_fl += int'(dir_flip);
    end
    tests++;
    if (n_wd != 1 || n_fl != 1 || n_wu != 1 || wrap_count !== 2'd2 || step_err !== 1'b0) begin
      failed++;
      $display("FAIL reversal_totals: got dn=%0d flip=%0d up=%0d count=%0d err=%0b want 1/1/1/2/0",
               n_wd, n_fl, n_wu, wrap_count, step_err);
    end
  endtask

  task automatic test_fault();
    logic [3:0] seq [0:6];
    seq = '{4'd2, 4'd3, 4'd5, 4'd15, 4'd0, 4'd1, 4'd2};
    drive(4'd0, 1'b1, 1'b1);
    exp_o = sb.pop_front(); obs_o = snap(); tests++;
    if (obs_o !== exp_o) begin failed++; $display("FAIL fault_clr: got %h want %h", obs_o, exp_o); end
    for (int i = 0; i < 7; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o) begin failed++; $display("FAIL fault[%0d]: got %h want %h", i, obs_o, exp_o); end
      if (i == 2) begin
        tests++;
        if (step_err !== 1'b1 || err_y !== 4'd5 || tracking !== 1'b0) begin
          failed++;
          $display("FAIL fault_latch: got err=%0b y=%0d trk=%0b want 1/5/0", step_err, err_y, tracking);
        end
      end
      if (i > 2) begin
        tests++;
        if (wrap_count !== 2'd0 || wrap_up !== 1'b0 || err_y !== 4'd5) begin
          failed++;
          $display("FAIL fault_frozen[%0d]: got count=%0d wu=%0b ey=%0d want 0/0/5", i, wrap_count, wrap_up, err_y);
        end
      end
    end
  endtask

  task automatic test_clear_priority();
    drive(4'd0, 1'b1, 1'b1);
    exp_o = sb.pop_front(); obs_o = snap(); tests++;
    if (obs_o !== exp_o) begin failed++; $display("FAIL clrpri_exit_fault: got %h want %h", obs_o, exp_o); end
    cy = 4'd14;
    for (int i = 0; i < 18; i++) begin
      drive(cy, 1'b1, 1'b0);
      cy = cy + 4'd1;
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o) begin failed++; $display("FAIL clrpri_run[%0d]: got %h want %h", i, obs_o, exp_o); end
    end
    tests++;
    if (wrap_count !== 2'd1) begin failed++; $display("FAIL clrpri_pre: got count=%0d want 1", wrap_count); end
    // cy is now 0: this edge would check a 15->0 wrap
    drive(cy, 1'b1, 1'b1);
    cy = cy + 4'd1;
    exp_o = sb.pop_front(); obs_o = snap(); tests++;
    if (obs_o !== exp_o || wrap_up !== 1'b0 || wrap_count !== 2'd0 || tracking !== 1'b0) begin
      failed++; $display("FAIL clrpri_edge: got %h want %h", obs_o, exp_o);
    end
    for (int i = 0; i < 2; i++) begin
      drive(cy, 1'b1, 1'b0);
      cy = cy + 4'd1;
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o || tracking !== 1'b1) begin
        failed++; $display("FAIL clrpri_resume[%0d]: got %h want %h", i, obs_o, exp_o);
      end
    end
  endtask

  task automatic test_saturation();
    int got_cnt [$];
    int want_cnt [5];
    want_cnt = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 80; i++) begin
      drive(cy, 1'b1, 1'b0);
      cy = cy + 4'd1;
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o) begin failed++; $display("FAIL sat[%0d]: got %h want %h", i, obs_o, exp_o); end
      if (wrap_up) got_cnt.push_back(int'(wrap_count));
    end
    tests++;
    if (got_cnt.size() != 5) begin
      failed++; $display("FAIL sat_pulses: got %0d want 5", got_cnt.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (got_cnt[i] != want_cnt[i]) begin
          failed++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, got_cnt[i], want_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fault();
    drive(cy + 4'd3, 1'b1, 1'b0);
    exp_o = sb.pop_front(); obs_o = snap(); tests++;
    if (obs_o !== exp_o || step_err !== 1'b1) begin
      failed++; $display("FAIL rst_fault_setup: got %h want %h", obs_o, exp_o);
    end
    #2 reset = 1'b1;
    #2;
    tests++;
    if (snap() !== obs_t'(0)) begin failed++; $display("FAIL rst_async: got %h want 0", snap()); end
    reset = 1'b0;
    model_reset();
    cy = 4'd7;
    for (int i = 0; i < 3; i++) begin
      // Third step skips a value: must be caught once checking has restarted
      drive((i == 2) ? 4'd10 : cy, 1'b1, 1'b0);
      cy = cy + 4'd1;
      exp_o = sb.pop_front(); obs_o = snap(); tests++;
      if (obs_o !== exp_o) begin failed++; $display("FAIL rst_restart[%0d]: got %h want %h", i, obs_o, exp_o); end
    end
    tests++;
    if (step_err !== 1'b1 || err_y !== 4'd10) begin
      failed++; $display("FAIL rst_recheck: got err=%0b y=%0d want 1/10", step_err, err_y);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_up_run();
    test_reversal();
    test_fault();
    test_clear_priority();
    test_saturation();
    test_reset_mid_fault();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
